// File: rtl/rgb_hsv_pkg.sv
// Shared types and helpers for the RGB->HSV pipeline: beat modes, hue sectors,
// reciprocal ROM contents and fixed-point rounding helpers.
package rgb_hsv_pkg;

  typedef enum logic {
    MODE_BYPASS = 1'b0,
    MODE_HSV    = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    SEC_R = 2'd0,
    SEC_G = 2'd1,
    SEC_B = 2'd2
  } sector_e;

  // floor(2^point / idx); entry 0 is defined as 0 so grey pixels read a harmless value
  function automatic int recip_init(input int point, input int cw, input int idx);
    if (idx <= 0 || idx >= (1 << cw)) return 0;
    return (1 << point) / idx;
  endfunction

  function automatic int half_lsb(input int point);
    return 1 << (point - 1);
  endfunction

  function automatic int sector_base(input sector_e sec);
    case (sec)
      SEC_G:   return 2;
      SEC_B:   return 4;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/rgb_to_hsv_pipe_if.sv
// Avalon-ST style beat bus (data, valid, ready, sop, eop) used on both sides of the converter.
interface rgb_to_hsv_pipe_if #(
  parameter int W = 24
) ();
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  logic         sop;
  logic         eop;

  modport master (output data, output valid, output sop, output eop, input ready);
  modport slave  (input data, input valid, input sop, input eop, output ready);
endinterface

// File: rtl/rgb_to_hsv_pipe_rom.sv
// Dual-read-port reciprocal ROM with registered outputs (one cycle latency).
module hsv_recip_rom
  import rgb_hsv_pkg::*;
#(
  parameter int CW    = 8,
  parameter int POINT = 12
) (
  input  logic           clk,
  input  logic           i_en,
  input  logic [CW-1:0]  i_addr_a,
  input  logic [CW-1:0]  i_addr_b,
  output logic [POINT:0] o_data_a,
  output logic [POINT:0] o_data_b
);
  localparam int DEPTH = 1 << CW;

  logic [POINT:0] w_rom [DEPTH];
  logic [POINT:0] r_data_a;
  logic [POINT:0] r_data_b;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign w_rom[gi] = (POINT + 1)'(recip_init(POINT, CW, gi));
  end

  // Enable follows the consuming stage so the read data stays aligned under stalls
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_data_a <= w_rom[i_addr_a];
      r_data_b <= w_rom[i_addr_b];
    end
  end

  assign o_data_a = r_data_a;
  assign o_data_b = r_data_b;
endmodule

// File: rtl/rgb_to_hsv_pipe.sv
// Three-stage elastic RGB->HSV converter; header (sop) and bypass beats pass through untouched.
module rgb_to_hsv_pipe
  import rgb_hsv_pkg::*;
#(
  parameter int CW        = 8,
  parameter int POINT     = 12,
  parameter int HUE_SCALE = 180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  rgb_to_hsv_pipe_if.slave   sink,
  rgb_to_hsv_pipe_if.master  source
);
  localparam int RW = POINT + 1;
  localparam int PW = CW + RW;
  localparam int QW = 2 * CW + RW;
  localparam int K  = HUE_SCALE / 6;
  localparam logic [CW-1:0] CH_MAX = '1;

  logic w_s1_load, w_s2_load, w_s3_load;
  logic r1_valid, r2_valid, r3_valid;

  assign w_s3_load  = !r3_valid || source.ready;
  assign w_s2_load  = !r2_valid || w_s3_load;
  assign w_s1_load  = !r1_valid || w_s2_load;
  assign sink.ready = w_s1_load;

  logic [CW-1:0] w_r, w_g, w_b, w_cmax, w_cmin, w_dmag;
  logic [CW:0]   w_d;
  sector_e       w_sector;

  assign {w_r, w_g, w_b} = sink.data;

  always_comb begin
    w_sector = SEC_B;
    w_cmax   = w_b;
    w_d      = {1'b0, w_r} - {1'b0, w_g};
    if (w_r >= w_g && w_r >= w_b) begin
      w_sector = SEC_R;
      w_cmax   = w_r;
      w_d      = {1'b0, w_g} - {1'b0, w_b};
    end else if (w_g >= w_b) begin
      w_sector = SEC_G;
      w_cmax   = w_g;
      w_d      = {1'b0, w_b} - {1'b0, w_r};
    end
    w_cmin = (w_r <= w_g) ? ((w_r <= w_b) ? w_r : w_b) : ((w_g <= w_b) ? w_g : w_b);
    w_dmag = w_d[CW] ? CW'(-w_d) : w_d[CW-1:0];
  end

  logic          r1_pass, r1_sop, r1_eop, r1_dneg;
  logic [3*CW-1:0] r1_data;
  sector_e       r1_sector;
  logic [CW-1:0] r1_dmag, r1_delta, r1_cmax;

  logic          r2_pass, r2_sop, r2_eop, r2_dneg;
  logic [3*CW-1:0] r2_data;
  sector_e       r2_sector;
  logic [CW-1:0] r2_dmag, r2_delta, r2_cmax;

  logic [RW-1:0] w_recip_delta, w_recip_cmax;

  hsv_recip_rom #(.CW(CW), .POINT(POINT)) u_rom (
    .clk      (clk),
    .i_en     (w_s2_load),
    .i_addr_a (r1_delta),
    .i_addr_b (r1_cmax),
    .o_data_a (w_recip_delta),
    .o_data_b (w_recip_cmax)
  );

  logic [PW-1:0] w_p;
  logic [QW-1:0] w_q;
  logic [QW:0]   w_q_rnd, w_q_sh;
  logic [CW-1:0] w_h, w_s;
  int            w_hacc;

  assign w_p     = PW'(r2_dmag) * PW'(w_recip_delta);
  assign w_q     = QW'(CH_MAX) * QW'(r2_delta) * QW'(w_recip_cmax);
  assign w_q_rnd = (QW + 1)'(w_q) + (QW + 1)'(half_lsb(POINT));
  assign w_q_sh  = w_q_rnd >> POINT;

  // Hue is accumulated signed so the sector-R negative side can wrap to the top of the circle
  always_comb begin
    w_hacc = K * (sector_base(r2_sector) * (1 << POINT) + (r2_dneg ? -int'(w_p) : int'(w_p)))
             + half_lsb(POINT);
    w_hacc = w_hacc >>> POINT;
    if (w_hacc < 0)
      w_hacc = w_hacc + HUE_SCALE;
    else if (w_hacc >= HUE_SCALE)
      w_hacc = w_hacc - HUE_SCALE;
    w_h = CW'(w_hacc);
    w_s = (w_q_sh > (QW + 1)'(CH_MAX)) ? CH_MAX : CW'(w_q_sh);
    if (r2_delta == r2_cmax) w_s = CH_MAX;
    if (r2_delta == '0) begin
      w_h = '0;
      w_s = '0;
    end
  end

  logic            r3_sop, r3_eop;
  logic [3*CW-1:0] r3_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_valid <= 1'b0; r1_pass <= 1'b0; r1_sop <= 1'b0; r1_eop <= 1'b0; r1_dneg <= 1'b0;
      r1_data  <= '0;   r1_sector <= SEC_R; r1_dmag <= '0; r1_delta <= '0; r1_cmax <= '0;
      r2_valid <= 1'b0; r2_pass <= 1'b0; r2_sop <= 1'b0; r2_eop <= 1'b0; r2_dneg <= 1'b0;
      r2_data  <= '0;   r2_sector <= SEC_R; r2_dmag <= '0; r2_delta <= '0; r2_cmax <= '0;
      r3_valid <= 1'b0; r3_sop <= 1'b0; r3_eop <= 1'b0; r3_data <= '0;
    end else begin
      if (w_s1_load) begin
        r1_valid  <= sink.valid;
        r1_pass   <= sink.sop || (mode_e'(mode) == MODE_BYPASS);
        r1_sop    <= sink.sop;
        r1_eop    <= sink.eop;
        r1_data   <= sink.data;
        r1_sector <= w_sector;
        r1_dneg   <= w_d[CW];
        r1_dmag   <= w_dmag;
        r1_delta  <= w_cmax - w_cmin;
        r1_cmax   <= w_cmax;
      end
      if (w_s2_load) begin
        r2_valid  <= r1_valid;
        r2_pass   <= r1_pass;
        r2_sop    <= r1_sop;
        r2_eop    <= r1_eop;
        r2_data   <= r1_data;
        r2_sector <= r1_sector;
        r2_dneg   <= r1_dneg;
        r2_dmag   <= r1_dmag;
        r2_delta  <= r1_delta;
        r2_cmax   <= r1_cmax;
      end
      if (w_s3_load) begin
        r3_valid <= r2_valid;
        r3_sop   <= r2_sop;
        r3_eop   <= r2_eop;
        r3_data  <= r2_pass ? r2_data : {w_h, w_s, r2_cmax};
      end
    end
  end

  assign source.valid = r3_valid;
  assign source.data  = r3_data;
  assign source.sop   = r3_sop;
  assign source.eop   = r3_eop;
endmodule

// File: tb/tb_rgb_to_hsv_pipe.sv
// Directed and stalled-stream checks of rgb_to_hsv_pipe against hand-derived HSV values.
module tb_rgb_to_hsv_pipe;
  logic clk = 1'b0;
  logic reset;
  logic mode;
  int   tests = 0;
  int   fails = 0;
  int   w;

  always #5 clk = ~clk;

  rgb_to_hsv_pipe_if #(.W(24)) sink_if ();
  rgb_to_hsv_pipe_if #(.W(24)) source_if ();

  rgb_to_hsv_pipe #(.CW(8), .POINT(12), .HUE_SCALE(180)) dut (
    .clk    (clk),
    .reset  (reset),
    .mode   (mode),
    .sink   (sink_if),
    .source (source_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted
  task automatic push(input logic [23:0] d, input logic s, input logic e, input logic m);
    int n;
    sink_if.data = d; sink_if.sop = s; sink_if.eop = e; mode = m; sink_if.valid = 1'b1;
    n = 0;
    while (!sink_if.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 32'(sink_if.ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic idle();
    sink_if.valid = 1'b0; sink_if.sop = 1'b0; sink_if.eop = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [23:0] ed, input logic es,
                            input logic ee, output int waited);
    waited = 0;
    while (!(source_if.valid && source_if.ready) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_vld"},  32'(source_if.valid), 32'd1);
    chk({tag, "_data"}, 32'(source_if.data), 32'(ed));
    chk({tag, "_tag"},  32'({source_if.sop, source_if.eop}), 32'({es, ee}));
    @(negedge clk);
  endtask

  function automatic logic [23:0] hsv_model(input logic [23:0] px);
    int r, g, b, mx, mn, dl, rc_d, rc_m, num, t, hue, s;
    r = int'(px[23:16]); g = int'(px[15:8]); b = int'(px[7:0]);
    mx = (r > g) ? r : g; mx = (mx > b) ? mx : b;
    mn = (r < g) ? r : g; mn = (mn < b) ? mn : b;
    dl = mx - mn;
    if (dl == 0) return {16'd0, 8'(mx)};
    rc_d = 4096 / dl;
    rc_m = 4096 / mx;
    if (r >= g && r >= b)  num = 30 * ((g - b) * rc_d);
    else if (g >= b)       num = 30 * (8192 + (b - r) * rc_d);
    else                   num = 30 * (16384 + (r - g) * rc_d);
    t   = num + 2048;
    hue = (t >= 0) ? t / 4096 : -((-t + 4095) / 4096);
    if (hue < 0) hue += 180;
    if (hue >= 180) hue -= 180;
    s = (dl == mx) ? 255 : (255 * dl * rc_m + 2048) / 4096;
    if (s > 255) s = 255;
    return {8'(hue), 8'(s), 8'(mx)};
  endfunction

  logic [25:0] exp_q[$];

  initial begin
    reset = 1'b1; mode = 1'b1;
    sink_if.valid = 1'b0; sink_if.data = '0; sink_if.sop = 1'b0; sink_if.eop = 1'b0;
    source_if.ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(source_if.valid), 32'd0);
    chk("rst_data",  32'(source_if.data), 32'd0);
    chk("rst_tag",   32'({source_if.sop, source_if.eop}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_sink_ready", 32'(sink_if.ready), 32'd1);

    // Pure red, also checks the three-cycle latency
    push(24'hFF0000, 1'b0, 1'b0, 1'b1); idle();
    chk("lat_c1", 32'(source_if.valid), 32'd0);
    @(negedge clk);
    chk("lat_c2", 32'(source_if.valid), 32'd0);
    @(negedge clk);
    chk("lat_c3", 32'(source_if.valid), 32'd1);
    expect_out("red", {8'd0, 8'd255, 8'd255}, 1'b0, 1'b0, w);

    push(24'h00FF00, 1'b0, 1'b0, 1'b1); idle(); expect_out("green",  {8'd60, 8'd255, 8'd255}, 1'b0, 1'b0, w);
    push(24'h0000FF, 1'b0, 1'b0, 1'b1); idle(); expect_out("blue",   {8'd120, 8'd255, 8'd255}, 1'b0, 1'b0, w);
    push(24'hFFFF00, 1'b0, 1'b0, 1'b1); idle(); expect_out("yellow", {8'd30, 8'd255, 8'd255}, 1'b0, 1'b0, w);
    push(24'h808080, 1'b0, 1'b0, 1'b1); idle(); expect_out("grey",   {8'd0, 8'd0, 8'd128}, 1'b0, 1'b0, w);
    push(24'h000000, 1'b0, 1'b0, 1'b1); idle(); expect_out("black",  24'h000000, 1'b0, 1'b0, w);
    push(24'hFFFFFF, 1'b1, 1'b1, 1'b1); idle(); expect_out("sopeop", 24'hFFFFFF, 1'b1, 1'b1, w);
    push(24'h123456, 1'b0, 1'b0, 1'b0); idle(); expect_out("bypass", 24'h123456, 1'b0, 1'b0, w);

    // Header followed by magenta, back to back
    push(24'h000000, 1'b1, 1'b0, 1'b1);
    push(24'hFF00FF, 1'b0, 1'b1, 1'b1); idle();
    expect_out("hdr", 24'h000000, 1'b1, 1'b0, w);
    expect_out("magenta", {8'd150, 8'd255, 8'd255}, 1'b0, 1'b1, w);
    chk("hdr_tput", 32'(w), 32'd0);

    // Per-beat mode toggle, filled while stalled then drained at full rate
    source_if.ready = 1'b0;
    push(24'hFF0000, 1'b0, 1'b0, 1'b1);
    push(24'hFF0000, 1'b0, 1'b0, 1'b0);
    push(24'h00FF00, 1'b0, 1'b0, 1'b1); idle();
    chk("stall_hold", 32'(source_if.valid), 32'd1);
    source_if.ready = 1'b1;
    expect_out("tog0", {8'd0, 8'd255, 8'd255}, 1'b0, 1'b0, w);
    chk("tog0_tput", 32'(w), 32'd0);
    expect_out("tog1", 24'hFF0000, 1'b0, 1'b0, w);
    chk("tog1_tput", 32'(w), 32'd0);
    expect_out("tog2", {8'd60, 8'd255, 8'd255}, 1'b0, 1'b0, w);
    chk("tog2_tput", 32'(w), 32'd0);

    // Random stream with random back-pressure
    fork
      begin
        logic [23:0] d;
        logic s, e, m;
        for (int i = 0; i < 100; i++) begin
          d = 24'($urandom);
          m = 1'($urandom_range(0, 1));
          s = ($urandom_range(0, 15) == 0);
          e = ($urandom_range(0, 15) == 0);
          exp_q.push_back({(s || !m) ? d : hsv_model(d), s, e});
          push(d, s, e, m);
          if ($urandom_range(0, 3) == 0) begin
            idle();
            @(negedge clk);
          end
        end
        idle();
      end
      begin
        int got, cyc;
        logic holding;
        logic [25:0] held, cur;
        got = 0; cyc = 0; holding = 1'b0; held = '0;
        while (got < 100 && cyc < 3000) begin
          @(posedge clk);
          #1 source_if.ready = ($urandom_range(0, 9) >= 3);
          @(negedge clk);
          cyc++;
          cur = {source_if.data, source_if.sop, source_if.eop};
          if (source_if.valid) begin
            if (holding) chk("stall_stable", 32'(cur), 32'(held));
            if (source_if.ready) begin
              chk("stream_pending", 32'(exp_q.size() != 0), 32'd1);
              if (exp_q.size() != 0) chk("stream_beat", 32'(cur), 32'(exp_q.pop_front()));
              got++;
              holding = 1'b0;
            end else begin
              holding = 1'b1;
              held = cur;
            end
          end
        end
        chk("stream_count", 32'(got), 32'd100);
      end
    join
    source_if.ready = 1'b1;
    @(negedge clk);

    // Reset with three beats in flight
    source_if.ready = 1'b0;
    push(24'hFF0000, 1'b0, 1'b0, 1'b1);
    push(24'h00FF00, 1'b0, 1'b0, 1'b1);
    push(24'h0000FF, 1'b0, 1'b0, 1'b1); idle();
    chk("inflight_valid", 32'(source_if.valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_async_valid", 32'(source_if.valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    source_if.ready = 1'b1;
    w = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (source_if.valid) w++;
    end
    chk("rst_flush", 32'(w), 32'd0);
    chk("rst_ready_after", 32'(sink_if.ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
